// File: rtl/led_pattern_gen.sv
// led_pattern_gen: drives N_LED outputs with an animated pattern advanced
// by a programmable free-running prescaler.
//   clk    : system clock
//   rst_n  : asynchronous active-low reset
//   en     : 1 = prescaler runs and pattern advances, 0 = freeze
//   mode   : 0 rotate-left, 1 rotate-right, 2 ping-pong, 3 blink-all
//   period : clock cycles per pattern step (0 and 1 both mean every cycle)
//   led    : LED drive, 1 = on
//   step   : one-cycle pulse coincident with each stepped led value
module led_pattern_gen #(
  parameter int N_LED = 8,
  parameter int CNT_W = 28
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [CNT_W-1:0] period,
  output logic [N_LED-1:0] led,
  output logic             step
);

  typedef enum logic [1:0] {
    M_ROTL  = 2'd0,
    M_ROTR  = 2'd1,
    M_PONG  = 2'd2,
    M_BLINK = 2'd3
  } mode_t;

  typedef enum logic {
    DIR_UP = 1'b0,
    DIR_DN = 1'b1
  } dir_t;

  localparam logic [N_LED-1:0] SEED    = N_LED'(1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_TWO = CNT_W'(2);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [N_LED-1:0] led_q, led_d;
  dir_t             dir_q, dir_d;
  mode_t            mode_q, mode_d;
  logic             step_q, step_d;

  mode_t            mode_in;
  logic [CNT_W-1:0] p_eff;
  logic             tc;
  logic             mode_chg;

  assign mode_in  = mode_t'(mode);
  assign p_eff    = (period < CNT_TWO) ? CNT_ONE : period;
  // >= rather than == so that shrinking the period below the current count
  // terminates on the next cycle instead of waiting for the counter to wrap.
  assign tc       = en && (cnt_q >= (p_eff - CNT_ONE));
  assign mode_chg = (mode_in != mode_q);

  always_comb begin
    cnt_d  = cnt_q;
    led_d  = led_q;
    dir_d  = dir_q;
    mode_d = mode_q;
    step_d = 1'b0;
    if (mode_chg) begin
      // Mode change wins over a coincident tc and applies even when frozen.
      mode_d = mode_in;
      cnt_d  = '0;
      if (mode_in == M_BLINK) begin
        led_d = '1;
      end else begin
        led_d = SEED;
        dir_d = DIR_UP;
      end
    end else if (tc) begin
      cnt_d  = '0;
      step_d = 1'b1;
      case (mode_q)
        M_ROTL:  led_d = {led_q[N_LED-2:0], led_q[N_LED-1]};
        M_ROTR:  led_d = {led_q[0], led_q[N_LED-1:1]};
        M_PONG: begin
          // Reverse on the end bit itself so the ends do not dwell.
          if (dir_q == DIR_UP) begin
            if (led_q[N_LED-1]) begin
              dir_d = DIR_DN;
              led_d = led_q >> 1;
            end else begin
              led_d = led_q << 1;
            end
          end else begin
            if (led_q[0]) begin
              dir_d = DIR_UP;
              led_d = led_q << 1;
            end else begin
              led_d = led_q >> 1;
            end
          end
        end
        default: led_d = ~led_q;
      endcase
    end else if (en) begin
      cnt_d = cnt_q + CNT_ONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      led_q  <= SEED;
      dir_q  <= DIR_UP;
      mode_q <= M_ROTL;
      step_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      led_q  <= led_d;
      dir_q  <= dir_d;
      mode_q <= mode_d;
      step_q <= step_d;
    end
  end

  assign led  = led_q;
  assign step = step_q;

endmodule

// File: doc/led_pattern_gen.md
Name: led_pattern_gen

Overview:
- Parametrised successor to the 2-LED toggle flasher. Drives N_LED outputs with a selectable animated pattern: rotate left, rotate right, ping-pong (bounce) or blink-all.
- Step rate comes from a free-running prescaler with a run-time programmable period.
- Sits between the board clock/reset and the user LED pins. It also provides a step strobe for other status logic.

Parameters:
- N_LED, 8, number of LED outputs; legal range 2..32.
- CNT_W, 28, width of the prescaler counter and the period input.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- en  input  1  1 = prescaler runs and pattern advances; 0 = freeze
- mode  input  2  0 rotate-left, 1 rotate-right, 2 ping-pong, 3 blink-all
- period  input  CNT_W  clock cycles per pattern step
- led  output  N_LED  LED drive, 1 = on
- step  output  1  one-cycle pulse, high in the same cycle that led takes a stepped value

Behaviour:
- Reset: rst_n is asynchronous, active-low; clock is clk. While rst_n=0 the block holds:
  - cnt=0
  - led = one-hot bit 0 (0...01)
  - dir=up
  - mode_q=0
  - step=0
- Effective period: P = (period<2) ? 1 : period. With P=1 the pattern steps every enabled cycle.
- Prescaler: while en=1, cnt increments each clk.
  - Terminal condition tc = en && (cnt >= P-1). Using >= means a period decrease below the current cnt terminates on the next cycle instead of waiting for wrap.
  - On tc, cnt <= 0.
  - While en=0, cnt holds and no step occurs.
- Step: step is registered and equals 1 exactly on the cycle after the edge where tc was true, i.e. coincident with the new led value. On all other cycles step=0.
- Pattern update on tc, by mode_q:
  - Rotate-left: led <= {led[N_LED-2:0], led[N_LED-1]}.
  - Rotate-right: led <= {led[0], led[N_LED-1:1]}.
  - Ping-pong: single lit bit moves toward the MSB while dir=up, toward the LSB while dir=down.
    - At bit N_LED-1 with dir=up: dir flips to down and the bit moves to N_LED-2 on the same step (no dwell at ends).
    - Symmetric at bit 0. Sequence for N_LED=4: 0,1,2,3,2,1,0,1...
  - Blink-all: led <= ~led, toggling between all-ones and all-zeros.
- Mode change: mode is sampled every cycle. If mode != mode_q, on that edge:
  - mode_q <= mode and cnt <= 0; no step is generated.
  - Seed load: modes 0/1/2 load led = one-hot bit 0 with dir=up; mode 3 loads led = all ones.
  - Mode change has priority over a coincident tc.
  - Mode change is applied even when en=0.
- Pattern invariants: in modes 0-2 led is always exactly one-hot; in mode 3 led is all-ones or all-zeros.
- Reset mid-operation: immediate return to the reset values, independent of clk. After release, the first step occurs P enabled cycles later.
- Period change: takes effect immediately via P. cnt is not cleared.
- Arithmetic: cnt never exceeds CNT_W bits. period=0 and period=1 behave identically.

Test Plan:
- Reset/basic rotate: N_LED=4, mode=0, period=3, en=1, release rst_n -> led 0001 for 3 cycles, then 0010, 0100, 1000, 0001; step high once per 3 cycles, aligned with each change.
- Rotate-right and ping-pong: mode=1 -> 0001 steps to 1000 then 0100. Switch to mode=2 -> led reloads 0001 with no step pulse, then 0010, 0100, 1000, 0100, 0010, 0001, 0010.
- Blink-all and en freeze: mode=3, period=2 -> led 1111, 0000, 1111 every 2 cycles. Drop en for 10 cycles -> led and cnt hold, no step. Raise en -> next toggle after the remaining count.
- Period boundaries: period=0 and then period=1 -> step every cycle. Set period=100, then after cnt reaches 50 set period=10 -> step on the next cycle, then every 10 cycles.
- Mode change coincident with tc and with en=0: change mode on the terminal cycle -> seed loaded, no step, cnt=0. Change mode with en=0 -> seed loaded, pattern otherwise frozen.
- Async reset mid-run: assert rst_n between clock edges in mode 2 with dir=down -> led=0001, step=0, cnt=0 immediately. After release, dir=up and the first step yields 0010.
